// File: rtl/xpb_accum_seq.sv
// xpb_accum_seq: sequential XPB lookup/accumulate stage for Montgomery ladder modular reduction.
//
// Purpose:
//   The block accepts one vector of REDUCT_SEGMENT high segments. It splits each segment into
//   LSB/CSB/MSB chunks and fetches one precomputed x*p*b entry per chunk from a loadable table
//   RAM, at one lookup per cycle. The fetched words are summed per word into a redundant result,
//   with no carry between words. The result is presented through a valid/ready handshake.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   in_valid/ready  input vector handshake; in_ready is high only in IDLE
//   high_segment    REDUCT_SEGMENT packed segments, segment i at [i*BIT_LEN +: BIT_LEN]
//   tbl_we/addr/    table write port; address = table_idx*64 + chunk; entry word j at
//   tbl_wdata       [j*WORD_LEN +: WORD_LEN]; writes are accepted only while idle
//   tbl_busy        high whenever the block is not idle
//   out_valid/ready result handshake
//   acc_out         NONREDUCT_SEGMENT sums, word j at [j*ACC_LEN +: ACC_LEN]
module xpb_accum_seq #(
    parameter int unsigned REDUCT_SEGMENT    = 19,
    parameter int unsigned NONREDUCT_SEGMENT = 16,
    parameter int unsigned WORD_LEN          = 16,
    parameter int unsigned BIT_LEN           = 17,
    parameter int unsigned LSB_W             = 5,
    parameter int unsigned CSB_W             = 6,
    parameter int unsigned MSB_W             = 6,
    parameter int unsigned ACC_LEN           = 22,
    localparam int unsigned TBL_AW           = $clog2(3 * REDUCT_SEGMENT * 64)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [REDUCT_SEGMENT*BIT_LEN-1:0]      high_segment,
    input  logic                                   tbl_we,
    input  logic [TBL_AW-1:0]                      tbl_addr,
    input  logic [NONREDUCT_SEGMENT*WORD_LEN-1:0]  tbl_wdata,
    output logic                                   tbl_busy,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [NONREDUCT_SEGMENT*ACC_LEN-1:0]   acc_out
);

    localparam int unsigned NUM_LK    = 3 * REDUCT_SEGMENT;
    localparam int unsigned TBL_DEPTH = NUM_LK * 64;
    localparam int unsigned KW        = $clog2(NUM_LK);
    localparam int unsigned SW        = (REDUCT_SEGMENT > 1) ? $clog2(REDUCT_SEGMENT) : 1;
    localparam int unsigned EW        = NONREDUCT_SEGMENT * WORD_LEN;

    // Elaboration-time parameter checks
    if (BIT_LEN != LSB_W + CSB_W + MSB_W) begin : g_bad_bit_len
        $error("xpb_accum_seq: BIT_LEN must equal LSB_W+CSB_W+MSB_W");
    end
    if (LSB_W > 6 || CSB_W > 6 || MSB_W > 6) begin : g_bad_chunk_w
        $error("xpb_accum_seq: chunk widths must not exceed 6 (64 slots per table)");
    end
    if (ACC_LEN < WORD_LEN + $clog2(NUM_LK)) begin : g_bad_acc_len
        $error("xpb_accum_seq: ACC_LEN too small for worst-case accumulation");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e                             state_q;
    logic [KW-1:0]                      k_q;        // lookup index == table index
    logic [SW-1:0]                      seg_idx_q;  // k_q / 3, tracked incrementally
    logic [1:0]                         part_q;     // k_q % 3: 0 lsb, 1 csb, 2 msb
    logic [REDUCT_SEGMENT*BIT_LEN-1:0]  seg_q;
    logic [ACC_LEN-1:0]                 acc_q [NONREDUCT_SEGMENT];
    logic                               rd_vld_q;
    logic [EW-1:0]                      rd_q;
    logic                               in_ready_q;
    logic                               out_valid_q;

    logic [EW-1:0]                      mem [TBL_DEPTH];

    logic [BIT_LEN-1:0]                 cur_seg;
    logic [5:0]                         chunk;
    logic [TBL_AW-1:0]                  rd_addr;
    logic                               issue;
    logic                               wr_en;

    assign issue   = (state_q == StRun);
    assign wr_en   = tbl_we && (state_q == StIdle) && (32'(tbl_addr) < TBL_DEPTH);
    assign cur_seg = seg_q[seg_idx_q*BIT_LEN +: BIT_LEN];

    always_comb begin
        chunk = '0;
        case (part_q)
            2'd0:    chunk = 6'(cur_seg[LSB_W-1:0]);
            2'd1:    chunk = 6'(cur_seg[LSB_W +: CSB_W]);
            default: chunk = 6'(cur_seg[LSB_W+CSB_W +: MSB_W]);
        endcase
    end

    // 64 slots per table, so the slot is simply appended below the table index
    assign rd_addr = TBL_AW'({k_q, chunk});

    // Table RAM: one write port, one synchronous read port, contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[tbl_addr] <= tbl_wdata;
        end
        if (issue) begin
            rd_q <= mem[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            k_q         <= '0;
            seg_idx_q   <= '0;
            part_q      <= '0;
            seg_q       <= '0;
            rd_vld_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            for (int j = 0; j < NONREDUCT_SEGMENT; j++) begin
                acc_q[j] <= '0;
            end
        end else begin
            rd_vld_q <= issue;
            // Read data lands one cycle after its issue; this also covers DRAIN
            if (rd_vld_q) begin
                for (int j = 0; j < NONREDUCT_SEGMENT; j++) begin
                    acc_q[j] <= acc_q[j] + ACC_LEN'(rd_q[j*WORD_LEN +: WORD_LEN]);
                end
            end
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        seg_q      <= high_segment;
                        k_q        <= '0;
                        seg_idx_q  <= '0;
                        part_q     <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= StRun;
                        for (int j = 0; j < NONREDUCT_SEGMENT; j++) begin
                            acc_q[j] <= '0;
                        end
                    end
                end
                StRun: begin
                    if (k_q == KW'(NUM_LK - 1)) begin
                        k_q       <= '0;
                        seg_idx_q <= '0;
                        part_q    <= '0;
                        state_q   <= StDrain;
                    end else begin
                        k_q <= k_q + 1'b1;
                        if (part_q == 2'd2) begin
                            part_q    <= 2'd0;
                            seg_idx_q <= seg_idx_q + 1'b1;
                        end else begin
                            part_q <= part_q + 2'd1;
                        end
                    end
                end
                StDrain: begin
                    out_valid_q <= 1'b1;
                    state_q     <= StDone;
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign tbl_busy  = !in_ready_q;
    assign out_valid = out_valid_q;

    for (genvar j = 0; j < NONREDUCT_SEGMENT; j++) begin : g_out
        assign acc_out[j*ACC_LEN +: ACC_LEN] = acc_q[j];
    end

endmodule

// File: tb/tb_xpb_accum_seq.sv
// Testbench for xpb_accum_seq: randomized and directed vectors, scoreboard plus monitor.
module tb_xpb_accum_seq;

    localparam int unsigned RS     = 19;
    localparam int unsigned NR     = 16;
    localparam int unsigned WL     = 16;
    localparam int unsigned BL     = 17;
    localparam int unsigned LW     = 5;
    localparam int unsigned CW     = 6;
    localparam int unsigned MW     = 6;
    localparam int unsigned AL     = 22;
    localparam int unsigned NUM_LK = 3 * RS;
    localparam int unsigned DEPTH  = NUM_LK * 64;
    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned EW     = NR * WL;

    typedef struct {
        logic [NR*AL-1:0] acc;
        int unsigned      c_acc;
    } exp_t;

    logic                 clk;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [RS*BL-1:0]     high_segment;
    logic                 tbl_we;
    logic [AW-1:0]        tbl_addr;
    logic [EW-1:0]        tbl_wdata;
    logic                 tbl_busy;
    logic                 out_valid;
    logic                 out_ready;
    logic [NR*AL-1:0]     acc_out;

    exp_t                 q[$];
    logic [EW-1:0]        tbl_m [DEPTH];
    int unsigned          cyc = 0;
    int unsigned          bp = 0;
    int                   n_chk = 0;
    int                   n_fail = 0;

    xpb_accum_seq #(
        .REDUCT_SEGMENT    (RS),
        .NONREDUCT_SEGMENT (NR),
        .WORD_LEN          (WL),
        .BIT_LEN           (BL),
        .LSB_W             (LW),
        .CSB_W             (CW),
        .MSB_W             (MW),
        .ACC_LEN           (AL)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .high_segment (high_segment),
        .tbl_we       (tbl_we),
        .tbl_addr     (tbl_addr),
        .tbl_wdata    (tbl_wdata),
        .tbl_busy     (tbl_busy),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .acc_out      (acc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Reference: for every segment, split into chunks arithmetically and sum table words.
    function automatic logic [NR*AL-1:0] model(input logic [RS*BL-1:0] segs);
        int unsigned      sum [NR];
        logic [NR*AL-1:0] r;
        logic [EW-1:0]    e;
        int unsigned      s;
        int unsigned      ch [3];
        for (int j = 0; j < NR; j++) sum[j] = 0;
        for (int i = 0; i < RS; i++) begin
            s     = int'(segs[i*BL +: BL]);
            ch[0] = s % (1 << LW);
            ch[1] = (s / (1 << LW)) % (1 << CW);
            ch[2] = s / (1 << (LW + CW));
            for (int p = 0; p < 3; p++) begin
                e = tbl_m[(3 * i + p) * 64 + ch[p]];
                for (int j = 0; j < NR; j++) sum[j] += int'(e[j*WL +: WL]);
            end
        end
        r = '0;
        for (int j = 0; j < NR; j++) r[j*AL +: AL] = AL'(sum[j]);
        return r;
    endfunction

    function automatic logic [RS*BL-1:0] rand_segs();
        logic [RS*BL-1:0] v;
        for (int i = 0; i < RS; i++) v[i*BL +: BL] = BL'($urandom);
        return v;
    endfunction

    // mode 0: words = slot index, 1: all 16'hFFFF, 2: zero, 3: random
    task automatic load(input int mode);
        logic [EW-1:0] e;
        for (int a = 0; a < DEPTH; a++) begin
            for (int j = 0; j < NR; j++) begin
                case (mode)
                    0:       e[j*WL +: WL] = WL'(a % 64);
                    1:       e[j*WL +: WL] = 16'hFFFF;
                    2:       e[j*WL +: WL] = '0;
                    default: e[j*WL +: WL] = WL'($urandom);
                endcase
            end
            tbl_we    = 1'b1;
            tbl_addr  = AW'(a);
            tbl_wdata = e;
            tbl_m[a]  = e;
            @(negedge clk);
        end
        tbl_we = 1'b0;
    endtask

    task automatic write1(input int a, input logic [EW-1:0] e);
        tbl_we    = 1'b1;
        tbl_addr  = AW'(a);
        tbl_wdata = e;
        tbl_m[a]  = e;
        @(negedge clk);
        tbl_we = 1'b0;
    endtask

    // Called at a negedge; the expected result is fixed by the model at acceptance.
    task automatic send(input logic [RS*BL-1:0] segs);
        exp_t e;
        int   n;
        e.acc        = model(segs);
        high_segment = segs;
        in_valid     = 1'b1;
        n            = 0;
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 512'(in_ready), 512'(1));
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        e.c_acc      = cyc;
        in_valid     = 1'b0;
        high_segment = rand_segs();  // must not affect the captured vector
        q.push_back(e);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(q.size() == 0 && in_ready && !out_valid) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) chk("drain_timeout", 512'(q.size()), 512'(0));
        @(negedge clk);
    endtask

    // Monitor: pops on each new result, checks latency, value, stability under backpressure
    initial begin
        exp_t             e;
        logic [NR*AL-1:0] snap;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 512'(out_valid), 512'(0));
                    out_ready = 1'b1;
                    @(negedge clk);
                    out_ready = 1'b0;
                    continue;
                end
                e = q.pop_front();
                chk("latency", 512'(cyc - e.c_acc), 512'(NUM_LK + 1));
                chk("acc_out", 512'(acc_out), 512'(e.acc));
                snap = acc_out;
                for (int h = 0; h < int'(bp); h++) begin
                    @(negedge clk);
                    chk("bp_valid", 512'(out_valid), 512'(1));
                    chk("bp_stable", 512'(acc_out), 512'(snap));
                    chk("bp_in_ready", 512'(in_ready), 512'(0));
                end
                out_ready = 1'b1;
                @(negedge clk);
                out_ready = 1'b0;
                chk("post_hs_valid", 512'(out_valid), 512'(0));
                chk("post_hs_in_ready", 512'(in_ready), 512'(1));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [RS*BL-1:0] s;
        logic [EW-1:0]    old_e;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        high_segment = '0;
        tbl_we       = 1'b0;
        tbl_addr     = '0;
        tbl_wdata    = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 512'(out_valid), 512'(0));
        chk("rst_in_ready", 512'(in_ready), 512'(1));
        chk("rst_tbl_busy", 512'(tbl_busy), 512'(0));
        chk("rst_acc", 512'(acc_out), 512'(0));

        // Chunk-index pattern with all-ones segments, then random segments
        load(0);
        for (int i = 0; i < RS; i++) s[i*BL +: BL] = 17'h1FFFF;
        send(s);
        wait_idle();
        for (int t = 0; t < 2; t++) begin
            send(rand_segs());
            wait_idle();
        end

        // Maximum accumulation with 10 cycles of backpressure; next vector waits with in_valid=1
        load(1);
        bp = 10;
        send(rand_segs());
        repeat (5) @(negedge clk);
        send(rand_segs());
        bp = 0;
        wait_idle();

        // Routing: only table 4 slot 0x2A non-zero
        load(2);
        for (int j = 0; j < NR; j++) old_e[j*WL +: WL] = WL'(j + 1);
        write1(4 * 64 + 'h2A, old_e);
        s = '0;
        s[1*BL +: BL] = 17'h00540;
        send(s);
        wait_idle();

        // Random table, random vectors, random backpressure
        load(3);
        for (int t = 0; t < 4; t++) begin
            bp = $urandom_range(0, 4);
            send(rand_segs());
            wait_idle();
        end
        bp = 0;

        // Write while busy must be dropped
        s = rand_segs();
        send(s);
        repeat (10) @(negedge clk);
        chk("busy_mid_run", 512'(tbl_busy), 512'(1));
        old_e     = tbl_m[int'(s[LW-1:0])];
        tbl_we    = 1'b1;
        tbl_addr  = AW'(int'(s[LW-1:0]));
        tbl_wdata = ~old_e;
        @(negedge clk);
        tbl_we = 1'b0;
        wait_idle();
        send(s);
        wait_idle();

        // Reset mid-run at k=20: no output, table preserved
        send(rand_segs());
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        q.delete();
        @(negedge clk);
        chk("mid_rst_out_valid", 512'(out_valid), 512'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_in_ready", 512'(in_ready), 512'(1));
        chk("mid_rst_tbl_busy", 512'(tbl_busy), 512'(0));
        chk("mid_rst_acc", 512'(acc_out), 512'(0));
        repeat (70) @(negedge clk);
        chk("mid_rst_no_output", 512'(out_valid), 512'(0));
        send(rand_segs());
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/xpb_accum_seq.md
Name: xpb_accum_seq

Overview:
Sequential, parametrised successor to the combinational XPB lookup stage used in Montgomery ladder modular reduction. It accepts one vector of REDUCT_SEGMENT high segments and splits each segment into LSB/CSB/MSB chunks. It fetches the precomputed x·p·b words from a runtime-loadable table RAM, one lookup per cycle, and accumulates them per word into a redundant (per-word, no inter-word carry) sum. The result feeds the downstream reduction adder tree through a valid/ready handshake. Replacing fixed ROM modules with a loadable table allows the modulus to change at runtime.

Parameters:
REDUCT_SEGMENT, 19, number of high segments per input vector
NONREDUCT_SEGMENT, 16, words per table entry and per output
WORD_LEN, 16, width of each table word
BIT_LEN, 17, width of each input segment; must equal LSB_W+CSB_W+MSB_W
LSB_W, 5, LSB chunk width (segment bits [LSB_W-1:0])
CSB_W, 6, CSB chunk width (next bits)
MSB_W, 6, MSB chunk width (top bits)
ACC_LEN, 22, accumulator/output word width; must be >= WORD_LEN+clog2(3*REDUCT_SEGMENT)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input vector valid
in_ready  out  1  block can accept an input vector
high_segment  in  REDUCT_SEGMENT x BIT_LEN  high segments
tbl_we  in  1  table write strobe
tbl_addr  in  clog2(3*REDUCT_SEGMENT*64)  table address = table_idx*64 + chunk
tbl_wdata  in  NONREDUCT_SEGMENT*WORD_LEN  entry; word j at [j*WORD_LEN +: WORD_LEN]
tbl_busy  out  1  high while not IDLE; writes are ignored
out_valid  out  1  accumulated result valid
out_ready  in  1  downstream accepts result
acc_out  out  NONREDUCT_SEGMENT x ACC_LEN  per-word redundant sums

Behaviour:
- Chunks: segment i = {msb, csb, lsb}. Segment i uses tables 3i (lsb), 3i+1 (csb), and 3i+2 (msb). Each table occupies 64 slots. The LSB table uses only slots 0..2^LSB_W-1.
- Table RAM: single write port and single synchronous read port. Read data appears 1 cycle after the address is presented. Contents are not reset.
- FSM: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - in_ready=1, tbl_busy=0.
  - tbl_we writes tbl_wdata to tbl_addr.
  - On in_valid&&in_ready, the block captures high_segment into an internal register, clears all accumulators to 0, sets lookup counter k=0, and moves to RUN.
- RUN:
  - Each cycle the block issues the read address for lookup k. k runs 0..3*REDUCT_SEGMENT-1, ordered lsb, csb, msb of segment 0, then segment 1, and so on.
  - Read data returned in the cycle after an issue is added word-wise into the accumulators: acc[j] += zero-extended word j.
  - After issuing k=3*REDUCT_SEGMENT-1, the FSM moves to DRAIN.
- DRAIN: accumulates the last read, then moves to DONE.
- DONE:
  - out_valid=1. acc_out holds stable until out_ready=1.
  - On out_valid&&out_ready, the FSM returns to IDLE.
  - in_ready=0 in DONE, so a new vector is accepted no earlier than the cycle after the handshake.
- Latency: out_valid rises exactly 3*REDUCT_SEGMENT+1 rising edges after the accepting edge (58 at defaults). Throughput is one vector per 3*REDUCT_SEGMENT+3 cycles minimum.
- Arithmetic: accumulation is unsigned and cannot overflow given the ACC_LEN constraint. There is no carry between words.
- in_ready = (state==IDLE). tbl_busy = !in_ready.
- tbl_we while tbl_busy: the write is dropped and the RAM is unchanged.
- Capture: high_segment is sampled only at acceptance. Later input changes have no effect on the result.
- Reset (asynchronous, any state including mid-RUN):
  - state←IDLE, k←0, accumulators←0.
  - out_valid=0, in_ready=1 once deasserted, tbl_busy=0.
  - Table contents are preserved. A partial computation is discarded and produces no output.
- Parameter checks: elaboration fails if BIT_LEN != LSB_W+CSB_W+MSB_W, if CSB_W>6 or MSB_W>6 or LSB_W>6, or if ACC_LEN is too small.

Test Plan:
- Chunk-index pattern: load every entry (t,c) with all words = c. Apply all segments = 17'h1FFFF. Required: out_valid 58 edges after acceptance, and every acc_out word = 19*(31+63+63) = 2983.
- Maximum accumulation: load every entry with all words 16'hFFFF. Apply any segments. Required: every word = 57*65535 = 22'h38FFC7, with no wrap.
- Routing: load only table 4 (segment 1 csb), slot 0x2A, with word j = j+1; all other entries 0. Set segment 1 = 17'h00540 (csb=0x2A) and all other segments 0. Required: acc_out[j] = j+1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE. Required: out_valid stays 1, acc_out is stable, and in_ready=0 despite in_valid=1. The FSM returns to IDLE one cycle after out_ready=1.
- Write while busy: pulse tbl_we mid-RUN. Required: the result is unchanged, and a subsequent run shows the old entry contents.
- Reset mid-RUN at k=20: required out_valid=0 with no output. A fresh vector afterwards gives the correct result using the preserved table.
